// File: rtl/arb_mux_nx1.sv
// N:1 valid/ready arbiter-mux (fixed priority, round-robin or external select) into one output register.
// Latency: 1 cycle from input accept to out_valid; one beat per cycle sustained.
// Backpressure: in_ready is only raised when the register is empty or draining this cycle.
module arb_mux_nx1 #(
    parameter int dataWidth = 32,
    parameter int numInputs = 4,
    parameter int selWidth  = $clog2(numInputs),
    parameter int MODE      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numInputs*dataWidth-1:0] in_data,
    input  logic [numInputs-1:0]           in_valid,
    output logic [numInputs-1:0]           in_ready,
    input  logic [selWidth-1:0]            sel,
    output logic [dataWidth-1:0]           out_data,
    output logic [selWidth-1:0]            out_src,
    output logic                           out_valid,
    input  logic                           out_ready
);

    logic [selWidth-1:0]  r_ptr;
    logic [dataWidth-1:0] r_out_data;
    logic [selWidth-1:0]  r_out_src;
    logic                 r_out_valid;

    logic [numInputs-1:0] w_grant;
    logic                 w_found;
    logic [selWidth-1:0]  w_gidx;
    logic [dataWidth-1:0] w_gdata;
    logic                 w_can_load;
    logic                 w_xfer;

    function automatic int rr_idx(input logic [selWidth-1:0] ptr, input int k);
        int j;
        j = int'(ptr) + k;
        if (j >= numInputs) j = j - numInputs;
        return j;
    endfunction

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        case (MODE)
            0: begin
                for (int i = 0; i < numInputs; i++) begin
                    if (!w_found && in_valid[i]) begin
                        w_grant[i] = 1'b1;
                        w_found    = 1'b1;
                    end
                end
            end
            1: begin
                for (int k = 0; k < numInputs; k++) begin
                    if (!w_found && in_valid[rr_idx(r_ptr, k)]) begin
                        w_grant[rr_idx(r_ptr, k)] = 1'b1;
                        w_found                   = 1'b1;
                    end
                end
            end
            default: begin
                // Out-of-range sel matches no channel, so it yields no grant.
                for (int i = 0; i < numInputs; i++) begin
                    if (sel == selWidth'(i) && in_valid[i]) begin
                        w_grant[i] = 1'b1;
                        w_found    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < numInputs; i++) begin
            if (w_grant[i]) begin
                w_gidx  = selWidth'(i);
                w_gdata = in_data[i*dataWidth +: dataWidth];
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign in_ready   = {numInputs{w_can_load & rst}} & w_grant;
    assign w_xfer     = |in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_gdata;
            r_out_src   <= w_gidx;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer moves past the winner only when a beat is actually taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gidx == selWidth'(numInputs - 1)) ? '0 : w_gidx + selWidth'(1);
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule
